cola_lector_destinos: RTL and testbench



---
 rtl/cola_lector_destinos.sv | 183 ++++++++++++++++++
 tb/tb_cola_lector_destinos.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cola_lector_destinos.sv
// cola_lector_destinos
// Sequential reader for the external-destination table. Walks the destination
// ROM from address 0 to NUM_DEST-1, captures each 2-bit floor code into a small
// FIFO and hands the codes to the elevator controller over valid/ready.
//
// Parameters:
//   NUM_DEST   - table entries read per run (1..256)
//   FIFO_DEPTH - output FIFO entries, power of two (2..16)
// Ports:
//   clk, rst_n  - rising-edge clock, asynchronous active-low reset
//   start       - one-cycle pulse, begins a run when idle
//   address     - ROM address currently presented
//   destino     - floor code returned by the ROM for address
//   dest_valid  - FIFO head holds a floor
//   dest_floor  - FIFO head floor code
//   dest_ready  - controller accepts the head when high with dest_valid
//   busy        - run in progress
//   done        - one-cycle pulse when the run ends
//   pending     - FIFO occupancy, 0..FIFO_DEPTH
// Configuration macro:
//   COLA_SKIP_REPEAT_EN - when defined, a code equal to the last code pushed in
//                         the current run is dropped instead of pushed.
module cola_lector_destinos #(
    parameter int unsigned NUM_DEST   = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] address,
    input  logic [1:0] destino,
    output logic       dest_valid,
    output logic [1:0] dest_floor,
    input  logic       dest_ready,
    output logic       busy,
    output logic       done,
    output logic [4:0] pending
);

    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam logic [7:0]  LAST_ADDR = 8'(NUM_DEST - 1);
    localparam logic [4:0]  FULL_CNT  = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        DRAIN
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    addr_q, addr_nx;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [4:0]    count;
    logic          done_q, done_nx;
    logic          push, pop, full;

`ifdef COLA_SKIP_REPEAT_EN
    logic [1:0]    last_code;
    logic          last_vld;
    logic          dup;
    logic          clr_last;

    assign dup = last_vld && (destino == last_code);
`endif

    // Fullness uses the registered count, so a same-cycle pop never makes
    // room for this cycle's push.
    assign full = (count == FULL_CNT);
    assign pop  = (count != '0) && dest_ready;

    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        push     = 1'b0;
        done_nx  = 1'b0;
`ifdef COLA_SKIP_REPEAT_EN
        clr_last = 1'b0;
`endif
        case (state)
            IDLE: begin
                addr_nx = '0;
                if (start) begin
                    state_nx = FETCH;
`ifdef COLA_SKIP_REPEAT_EN
                    clr_last = 1'b1;
`endif
                end
            end
            FETCH: begin
                state_nx = CAPTURE;
            end
            CAPTURE: begin
`ifdef COLA_SKIP_REPEAT_EN
                // A repeated code is dropped and the walk advances even when
                // the FIFO is full, since nothing needs to be stored.
                if (dup || !full) begin
                    push = !dup;
`else
                if (!full) begin
                    push = 1'b1;
`endif
                    if (addr_q == LAST_ADDR) begin
                        state_nx = DRAIN;
                    end else begin
                        addr_nx  = addr_q + 8'd1;
                        state_nx = FETCH;
                    end
                end
            end
            DRAIN: begin
                if (count == '0) begin
                    state_nx = IDLE;
                    addr_nx  = '0;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                addr_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            addr_q <= addr_nx;
            done_q <= done_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= destino;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef COLA_SKIP_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_code <= '0;
            last_vld  <= 1'b0;
        end else if (clr_last) begin
            last_vld  <= 1'b0;
        end else if (push) begin
            last_code <= destino;
            last_vld  <= 1'b1;
        end
    end
`endif

    assign address    = addr_q;
    assign dest_valid = (count != '0);
    assign dest_floor = mem[rd_ptr];
    assign busy       = (state != IDLE);
    assign done       = done_q;
    assign pending    = count;

endmodule

// File: tb/tb_cola_lector_destinos.sv
// Directed testbench for cola_lector_destinos: walks a 10-entry ROM and checks
// the delivered floor sequence, stall behaviour, mid-run reset and start
// pulses while busy.
module tb_cola_lector_destinos;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] address;
    logic [1:0] destino;
    logic       dest_valid;
    logic [1:0] dest_floor;
    logic       dest_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [4:0] pending;

    int n_cmp = 0;
    int n_err = 0;

    logic [1:0] rom [10] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};

`ifdef COLA_SKIP_REPEAT_EN
    localparam int NEXP = 9;
    localparam int STALL_ADDR = 5;
    logic [1:0] expq [NEXP] = '{2'd3, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
`else
    localparam int NEXP = 10;
    localparam int STALL_ADDR = 4;
    logic [1:0] expq [NEXP] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
`endif

    always #5 clk = ~clk;

    always_comb destino = (address < 8'd10) ? rom[address[3:0]] : 2'b00;

    cola_lector_destinos #(
        .NUM_DEST  (10),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .address   (address),
        .destino   (destino),
        .dest_valid(dest_valid),
        .dest_floor(dest_floor),
        .dest_ready(dest_ready),
        .busy      (busy),
        .done      (done),
        .pending   (pending)
    );

    // Pop/done observer, sampled on the falling edge.
    logic [1:0] got [$];
    int done_cnt      = 0;
    int done_w_busy   = 0;
    int cyc           = 0;
    int last_pop_cyc  = 0;
    int done_cyc      = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (dest_valid && dest_ready) begin
                got.push_back(dest_floor);
                last_pop_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) done_w_busy++;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic clear_obs();
        got.delete();
        done_cnt    = 0;
        done_w_busy = 0;
    endtask

    task automatic chk_sequence(input string tag);
        chk({tag, "_count"}, got.size(), NEXP);
        for (int i = 0; i < NEXP && i < got.size(); i++) begin
            chk($sformatf("%s_floor%0d", tag, i), {30'd0, got[i]}, {30'd0, expq[i]});
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_done_busy"}, done_w_busy, 0);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_addr_end"}, {24'd0, address}, 32'd0);
        chk({tag, "_pend_end"}, {27'd0, pending}, 32'd0);
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_address", {24'd0, address}, 32'd0);
        chk("rst_valid", {31'd0, dest_valid}, 32'd0);
        chk("rst_floor", {30'd0, dest_floor}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pending", {27'd0, pending}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        // Run 1: ready held high, start latency, stray start while busy
        dest_ready = 1'b1;
        clear_obs();
        pulse_start();
        chk("t1_busy_n1", {31'd0, busy}, 32'd1);
        chk("t1_valid_n1", {31'd0, dest_valid}, 32'd0);
        chk("t1_addr_n1", {24'd0, address}, 32'd0);
        @(negedge clk);
        chk("t1_valid_n2", {31'd0, dest_valid}, 32'd0);
        @(negedge clk);
        chk("t1_valid_n3", {31'd0, dest_valid}, 32'd1);
        chk("t1_floor_n3", {30'd0, dest_floor}, 32'd3);
        chk("t1_addr_n3", {24'd0, address}, 32'd1);
        chk("t1_pend_n3", {27'd0, pending}, 32'd1);
        repeat (3) @(negedge clk);
        pulse_start();
        wait_idle(100);
        chk_sequence("t1");
        chk("t1_done_lag", done_cyc - last_pop_cyc, 2);

        // Run 2: ready low fills the FIFO, then single pop while stalled
        dest_ready = 1'b0;
        clear_obs();
        pulse_start();
        repeat (30) @(negedge clk);
        chk("t2_pend_full", {27'd0, pending}, 32'd4);
        chk("t2_addr_stall", {24'd0, address}, STALL_ADDR);
        chk("t2_valid", {31'd0, dest_valid}, 32'd1);
        chk("t2_head", {30'd0, dest_floor}, 32'd3);
        chk("t2_busy", {31'd0, busy}, 32'd1);
        dest_ready = 1'b1;
        @(negedge clk);
        dest_ready = 1'b0;
        chk("t2_pend_pop", {27'd0, pending}, 32'd3);
        chk("t2_addr_pop", {24'd0, address}, STALL_ADDR);
        @(negedge clk);
        chk("t2_pend_refill", {27'd0, pending}, 32'd4);
        chk("t2_addr_adv", {24'd0, address}, STALL_ADDR + 1);
        dest_ready = 1'b1;
        wait_idle(200);
        chk_sequence("t2");

        // Run 3: reset mid-run after three pushes, then a clean restart
        dest_ready = 1'b0;
        clear_obs();
        pulse_start();
        for (int i = 0; i < 20 && pending != 5'd3; i++) @(negedge clk);
        chk("t3_pend_pre", {27'd0, pending}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("t3_rst_address", {24'd0, address}, 32'd0);
        chk("t3_rst_valid", {31'd0, dest_valid}, 32'd0);
        chk("t3_rst_floor", {30'd0, dest_floor}, 32'd0);
        chk("t3_rst_busy", {31'd0, busy}, 32'd0);
        chk("t3_rst_done", {31'd0, done}, 32'd0);
        chk("t3_rst_pending", {27'd0, pending}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t3_no_done", done_cnt, 0);
        dest_ready = 1'b1;
        clear_obs();
        pulse_start();
        chk("t3_restart_addr", {24'd0, address}, 32'd0);
        chk("t3_restart_busy", {31'd0, busy}, 32'd1);
        wait_idle(100);
        chk_sequence("t3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
